// File: rtl/capture_seq_if.sv
// Signal bundle between the capture sequencer and its neighbours: the
// control register block (configuration and status), the trigger
// comparators (sample_valid / level_hit) and the sample buffer write port.
// The controlling side uses the master modport, the sequencer uses slave.
interface capture_seq_if #(
  parameter int saddr_w = 24,
  parameter int levels  = 8
);
  localparam int lvl_w = $clog2(levels) + 1;
  localparam int cur_w = $clog2(levels);

  // Control and configuration
  logic               arm;
  logic               abort;
  logic [saddr_w-1:0] buffer_size;
  logic [saddr_w-1:0] pre_count;
  logic [saddr_w-1:0] post_count;
  logic [lvl_w-1:0]   num_levels;

  // Sample stream from the trigger comparators
  logic               sample_valid;
  logic [levels-1:0]  level_hit;

  // Buffer write port
  logic               wr_en;
  logic [saddr_w-1:0] wr_addr;

  // Status back to the control register block
  logic               ready;
  logic               armed;
  logic               triggered;
  logic               done;
  logic [cur_w-1:0]   cur_level;
  logic [saddr_w-1:0] trigger_pos;
  logic [saddr_w-1:0] start_addr;

  modport master (
    output arm, abort, buffer_size, pre_count, post_count, num_levels,
           sample_valid, level_hit,
    input  wr_en, wr_addr, ready, armed, triggered, done, cur_level,
           trigger_pos, start_addr
  );

  modport slave (
    input  arm, abort, buffer_size, pre_count, post_count, num_levels,
           sample_valid, level_hit,
    output wr_en, wr_addr, ready, armed, triggered, done, cur_level,
           trigger_pos, start_addr
  );
endinterface

// File: rtl/capture_seq.sv
// Capture sequencer for the logic analyzer. Walks arm -> pre-trigger fill ->
// multi-level trigger -> post-trigger count -> done, drives the circular
// buffer write address, and reports where the trigger sample and the oldest
// valid sample live in the buffer. Everything runs in the sample clock domain.
module capture_seq #(
  parameter int saddr_w = 24,
  parameter int levels  = 8
) (
  input  logic         clk,
  input  logic         reset,
  capture_seq_if.slave bus
);

  localparam int lvl_w = $clog2(levels) + 1;
  localparam int cur_w = $clog2(levels);

  localparam logic [saddr_w-1:0] addr_one = 1;
  localparam logic [lvl_w-1:0]   lvl_one  = 1;
  localparam logic [cur_w-1:0]   cur_one  = 1;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT_TRIG,
    POST,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Configuration latched at arm (post_count is latched on entry to POST)
  logic [saddr_w-1:0] n_lat, n_nxt;
  logic [saddr_w-1:0] pre_lat, pre_nxt;
  logic [saddr_w-1:0] post_lat, post_nxt;
  logic [lvl_w-1:0]   lvl_lat, lvl_nxt;

  // Capture progress
  logic [saddr_w-1:0] addr_q, addr_nxt;
  logic [saddr_w-1:0] cnt_q, cnt_nxt;
  logic               wrapped_q, wrapped_nxt;
  logic [cur_w-1:0]   cur_q, cur_nxt;
  logic               trig_q, trig_nxt;
  logic [saddr_w-1:0] tpos_q, tpos_nxt;
  logic [saddr_w-1:0] start_q, start_nxt;

  // Helper terms
  logic               capturing;
  logic               wr_en_int;
  logic               wrap_inc;
  logic [saddr_w-1:0] addr_inc;
  logic [saddr_w-1:0] cnt_inc;
  logic [saddr_w-1:0] pre_clamped;
  logic               hit_cur;
  logic               final_hit;
  logic               do_arm;
  logic               do_advance;
  logic               enter_done;

  // Shared arithmetic: modulo-N address step, counter step, pre_count clamp
  // and the trigger decision for the level currently awaited. A latched size
  // of zero means the full 2^saddr_w buffer, which n_lat - 1 handles by
  // wrapping to all ones.
  always_comb begin
    capturing = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);
    wr_en_int = bus.sample_valid & capturing & ~reset;
    wrap_inc  = (addr_q == (n_lat - addr_one));
    addr_inc  = wrap_inc ? '0 : (addr_q + addr_one);
    cnt_inc   = cnt_q + addr_one;
    hit_cur   = bus.level_hit[cur_q];
    final_hit = (lvl_lat == '0) ||
                (hit_cur && ({1'b0, cur_q} == (lvl_lat - lvl_one)));
    if (bus.buffer_size == '0) begin
      pre_clamped = bus.pre_count;
    end else if (bus.pre_count >= bus.buffer_size) begin
      pre_clamped = bus.buffer_size - addr_one;
    end else begin
      pre_clamped = bus.pre_count;
    end
  end

  // Next-state and next-register logic. Abort beats arm beats sample_valid;
  // a sample arriving in an abort cycle is written but neither counted nor
  // allowed to move the write address.
  always_comb begin
    state_nxt   = state;
    n_nxt       = n_lat;
    pre_nxt     = pre_lat;
    post_nxt    = post_lat;
    lvl_nxt     = lvl_lat;
    addr_nxt    = addr_q;
    cnt_nxt     = cnt_q;
    wrapped_nxt = wrapped_q;
    cur_nxt     = cur_q;
    trig_nxt    = trig_q;
    tpos_nxt    = tpos_q;
    start_nxt   = start_q;
    do_arm      = 1'b0;
    do_advance  = 1'b0;
    enter_done  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.arm) begin
          do_arm = 1'b1;
        end
      end

      PREFILL: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          trig_nxt  = 1'b0;
        end else if (bus.sample_valid) begin
          do_advance = 1'b1;
          cnt_nxt    = cnt_inc;
          if (cnt_inc == pre_lat) begin
            state_nxt = WAIT_TRIG;
            cnt_nxt   = '0;
          end
        end
      end

      WAIT_TRIG: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          trig_nxt  = 1'b0;
        end else if (bus.sample_valid) begin
          do_advance = 1'b1;
          if (final_hit) begin
            trig_nxt = 1'b1;
            tpos_nxt = addr_q;
            post_nxt = bus.post_count;
            cnt_nxt  = '0;
            if (bus.post_count == '0) begin
              state_nxt  = DONE;
              enter_done = 1'b1;
            end else begin
              state_nxt = POST;
            end
          end else if (hit_cur) begin
            cur_nxt = cur_q + cur_one;
          end
        end
      end

      POST: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          trig_nxt  = 1'b0;
        end else if (bus.sample_valid) begin
          do_advance = 1'b1;
          cnt_nxt    = cnt_inc;
          if (cnt_inc == post_lat) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end
        end
      end

      DONE: begin
        if (bus.abort) begin
          state_nxt = IDLE;
          trig_nxt  = 1'b0;
        end else if (bus.arm) begin
          do_arm = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (do_advance) begin
      addr_nxt = addr_inc;
      if (wrap_inc) begin
        wrapped_nxt = 1'b1;
      end
    end

    // The oldest valid sample is the next write slot once the buffer has
    // wrapped, otherwise slot 0. This looks at the post-write address/flag.
    if (enter_done) begin
      start_nxt = (wrapped_q | wrap_inc) ? addr_inc : '0;
    end

    if (do_arm) begin
      n_nxt       = bus.buffer_size;
      pre_nxt     = pre_clamped;
      lvl_nxt     = bus.num_levels;
      addr_nxt    = '0;
      cnt_nxt     = '0;
      wrapped_nxt = 1'b0;
      cur_nxt     = '0;
      trig_nxt    = 1'b0;
      state_nxt   = (pre_clamped == '0) ? WAIT_TRIG : PREFILL;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      n_lat     <= '0;
      pre_lat   <= '0;
      post_lat  <= '0;
      lvl_lat   <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
      cur_q     <= '0;
      trig_q    <= 1'b0;
      tpos_q    <= '0;
      start_q   <= '0;
    end else begin
      state     <= state_nxt;
      n_lat     <= n_nxt;
      pre_lat   <= pre_nxt;
      post_lat  <= post_nxt;
      lvl_lat   <= lvl_nxt;
      addr_q    <= addr_nxt;
      cnt_q     <= cnt_nxt;
      wrapped_q <= wrapped_nxt;
      cur_q     <= cur_nxt;
      trig_q    <= trig_nxt;
      tpos_q    <= tpos_nxt;
      start_q   <= start_nxt;
    end
  end

  assign bus.wr_en       = wr_en_int;
  assign bus.wr_addr     = addr_q;
  assign bus.ready       = (state == IDLE);
  assign bus.armed       = (state == PREFILL) || (state == WAIT_TRIG);
  assign bus.triggered   = trig_q;
  assign bus.done        = (state == DONE);
  assign bus.cur_level   = cur_q;
  assign bus.trigger_pos = tpos_q;
  assign bus.start_addr  = start_q;

endmodule

// File: tb/tb_capture_seq.sv
// Bench for capture_seq: directed capture scenarios, a sample-count based
// reference model compared on every falling edge, and literal spot checks.
module tb_capture_seq;

  localparam int saddr_w = 24;
  localparam int levels  = 8;

  logic clk = 1'b0;
  logic reset;
  bit   check_en = 1'b0;
  int   total = 0;
  int   bad   = 0;

  capture_seq_if #(.saddr_w(saddr_w), .levels(levels)) bus ();

  capture_seq #(.saddr_w(saddr_w), .levels(levels)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model in terms of sample indices since arm
  bit     m_active, m_trig, m_done;
  longint m_k, m_n, m_pre, m_post, m_tidx, m_tpos, m_start;
  int     m_lvl, m_cur;

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    longint n;
    if (reset) begin
      m_active = 0; m_trig = 0; m_done = 0;
      m_k = 0; m_n = 64'd1 << saddr_w; m_pre = 0; m_post = 0;
      m_tidx = 0; m_tpos = 0; m_start = 0; m_lvl = 0; m_cur = 0;
    end else if (bus.abort && (m_active || m_done)) begin
      m_active = 0; m_trig = 0; m_done = 0;
    end else if (bus.arm && !m_active) begin
      n = (bus.buffer_size == 0) ? (64'd1 << saddr_w) : longint'(bus.buffer_size);
      m_n = n;
      m_pre = (longint'(bus.pre_count) > n - 1) ? n - 1 : longint'(bus.pre_count);
      m_lvl = int'(bus.num_levels);
      m_k = 0; m_cur = 0; m_trig = 0; m_done = 0; m_active = 1;
    end else if (m_active && bus.sample_valid) begin
      if (!m_trig && m_k >= m_pre) begin
        if (m_lvl == 0 || (bus.level_hit[m_cur] && m_cur == m_lvl - 1)) begin
          m_trig = 1; m_tidx = m_k; m_tpos = m_k % m_n;
          m_post = longint'(bus.post_count);
        end else if (bus.level_hit[m_cur]) begin
          m_cur++;
        end
      end
      m_k++;
      if (m_trig && m_k == m_tidx + 1 + m_post) begin
        m_active = 0; m_done = 1;
        m_start = (m_k >= m_n) ? m_k % m_n : 0;
      end
    end
  endtask

  // Advance the model on every active edge using the bench-driven inputs
  always @(posedge clk) model_step();

  // Compare every DUT output against the model away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      check_output("wr_en", bus.wr_en, bus.sample_valid && m_active && !reset);
      check_output("wr_addr", bus.wr_addr, m_k % m_n);
      check_output("ready", bus.ready, !m_active && !m_done);
      check_output("armed", bus.armed, m_active && !m_trig);
      check_output("triggered", bus.triggered, m_trig);
      check_output("done", bus.done, m_done);
      check_output("cur_level", bus.cur_level, m_cur);
      check_output("trigger_pos", bus.trigger_pos, m_tpos);
      check_output("start_addr", bus.start_addr, m_start);
    end
  end

  task automatic configure(input int bs, input int pre, input int post, input int lv);
    bus.buffer_size = bs[saddr_w-1:0];
    bus.pre_count   = pre[saddr_w-1:0];
    bus.post_count  = post[saddr_w-1:0];
    bus.num_levels  = lv[3:0];
  endtask

  // Present one cycle of control/sample inputs, return just after the edge
  task automatic apply_stimulus(input logic a, input logic ab, input logic sv,
                                input logic [7:0] hit);
    bus.arm          = a;
    bus.abort        = ab;
    bus.sample_valid = sv;
    bus.level_hit    = hit;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] hits3 [12];

  initial begin
    for (int i = 0; i < 12; i++) hits3[i] = 8'h00;
    hits3[5] = 8'h03; hits3[6] = 8'h04; hits3[7] = 8'h02;
    hits3[8] = 8'h01; hits3[9] = 8'h04;

    reset = 1'b1;
    configure(0, 0, 0, 0);
    bus.arm = 0; bus.abort = 0; bus.sample_valid = 0; bus.level_hit = 0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    apply_stimulus(0, 0, 0, 8'h00);
    check_output("rst_ready", bus.ready, 1);
    check_output("rst_wr_addr", bus.wr_addr, 0);
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 8'h00);

    // N=16 pre=4 post=5, single level; early hit on sample 2 is ignored
    $display("[TB] scenario: basic capture");
    configure(16, 4, 5, 1);
    apply_stimulus(1, 0, 0, 8'h00);
    check_output("s1_armed", bus.armed, 1);
    for (int s = 0; s < 11; s++) begin
      apply_stimulus(0, 0, 1, (s == 2 || s == 6) ? 8'h01 : 8'h00);
      if (s == 5) check_output("s1_no_early_trig", bus.triggered, 0);
    end
    check_output("s1_done_before_last", bus.done, 0);
    apply_stimulus(0, 0, 1, 8'h00);
    check_output("s1_done", bus.done, 1);
    check_output("s1_tpos", bus.trigger_pos, 6);
    check_output("s1_start", bus.start_addr, 0);
    apply_stimulus(0, 0, 0, 8'h00);

    // N=8 pre=2 post=3, trigger at sample 10, buffer wraps; arm from DONE
    $display("[TB] scenario: wrapped capture");
    configure(8, 2, 3, 1);
    apply_stimulus(1, 0, 0, 8'h00);
    for (int s = 0; s < 14; s++) apply_stimulus(0, 0, 1, (s == 10) ? 8'h01 : 8'h00);
    check_output("s2_done", bus.done, 1);
    check_output("s2_tpos", bus.trigger_pos, 2);
    check_output("s2_start", bus.start_addr, 6);
    check_output("s2_wr_addr", bus.wr_addr, 6);

    // Three levels, pre=0: one advance per sample, only the awaited level counts
    $display("[TB] scenario: multi-level trigger");
    configure(16, 0, 2, 3);
    apply_stimulus(1, 0, 0, 8'h00);
    for (int s = 0; s < 12; s++) begin
      apply_stimulus(0, 0, 1, hits3[s]);
      if (s == 5) check_output("s3_level_after5", bus.cur_level, 1);
      if (s == 6) check_output("s3_level_after6", bus.cur_level, 1);
      if (s == 7) check_output("s3_level_after7", bus.cur_level, 2);
    end
    check_output("s3_done", bus.done, 1);
    check_output("s3_tpos", bus.trigger_pos, 9);

    // Forced trigger (num_levels=0) with post=0 goes straight to DONE
    $display("[TB] scenario: forced trigger");
    configure(16, 3, 0, 0);
    apply_stimulus(1, 0, 0, 8'h00);
    for (int s = 0; s < 3; s++) apply_stimulus(0, 0, 1, 8'h00);
    check_output("s4_not_yet", bus.triggered, 0);
    apply_stimulus(0, 0, 1, 8'h00);
    check_output("s4_done", bus.done, 1);
    check_output("s4_trig", bus.triggered, 1);
    check_output("s4_tpos", bus.trigger_pos, 3);

    // Arm ignored in POST, abort with a sample, then re-arm with a sample
    $display("[TB] scenario: abort and restart");
    configure(16, 1, 10, 1);
    apply_stimulus(1, 0, 0, 8'h00);
    for (int s = 0; s < 3; s++) apply_stimulus(0, 0, 1, (s == 2) ? 8'h01 : 8'h00);
    apply_stimulus(1, 0, 1, 8'h00);
    check_output("s5_arm_ignored", bus.ready, 0);
    check_output("s5_still_trig", bus.triggered, 1);
    apply_stimulus(0, 1, 1, 8'h00);
    check_output("s5_abort_ready", bus.ready, 1);
    check_output("s5_abort_trig", bus.triggered, 0);
    check_output("s5_abort_done", bus.done, 0);
    apply_stimulus(1, 0, 1, 8'h00);
    check_output("s5_rearm_addr", bus.wr_addr, 0);
    check_output("s5_rearm_armed", bus.armed, 1);
    apply_stimulus(0, 0, 1, 8'h00);
    apply_stimulus(0, 1, 0, 8'h00);

    // pre_count larger than the buffer is clamped to N-1
    $display("[TB] scenario: pre_count clamp");
    configure(4, 9, 1, 1);
    apply_stimulus(1, 0, 0, 8'h00);
    for (int s = 0; s < 5; s++) apply_stimulus(0, 0, 1, (s == 2 || s == 3) ? 8'h01 : 8'h00);
    check_output("s7_done", bus.done, 1);
    check_output("s7_tpos", bus.trigger_pos, 3);
    check_output("s7_start", bus.start_addr, 1);

    // Reset in WAIT_TRIG with a sample present
    $display("[TB] scenario: mid-capture reset");
    configure(16, 0, 3, 2);
    apply_stimulus(1, 0, 0, 8'h00);
    for (int s = 0; s < 4; s++) apply_stimulus(0, 0, 1, (s == 1) ? 8'h01 : 8'h00);
    check_output("s6_level", bus.cur_level, 1);
    reset = 1'b1;
    bus.sample_valid = 1'b1;
    #1;
    check_output("s6_wr_en_in_reset", bus.wr_en, 0);
    @(posedge clk);
    #1;
    check_output("s6_ready", bus.ready, 1);
    check_output("s6_armed", bus.armed, 0);
    check_output("s6_wr_addr", bus.wr_addr, 0);
    check_output("s6_cur_level", bus.cur_level, 0);
    check_output("s6_tpos", bus.trigger_pos, 0);
    check_output("s6_start", bus.start_addr, 0);
    reset = 1'b0;
    apply_stimulus(0, 0, 0, 8'h00);
    apply_stimulus(0, 0, 0, 8'h00);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_seq.md
Name: capture_seq

Overview:
- Capture sequencer for the logic analyzer.
- Owns the capture state machine: arm, pre-trigger fill, multi-level trigger walk, post-trigger count, done.
- Generates circular-buffer write addresses and reports trigger position and oldest-sample address to the control register block.
- Sits between the trigger comparators (per-level hit vector) and the sample buffer write port, in the sample clock domain.

Parameters:
- saddr_w, 24, sample buffer address width.
- levels, 8, number of trigger levels (stages).

Ports:
- clk  in  1  sample-domain clock.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle arm request.
- abort  in  1  single-cycle abort request.
- buffer_size  in  saddr_w  buffer depth N; 0 means 2^saddr_w.
- pre_count  in  saddr_w  pre-trigger samples required before triggers are honoured.
- post_count  in  saddr_w  samples captured after the trigger sample.
- num_levels  in  $clog2(levels)+1  active trigger levels; 0 means force trigger.
- sample_valid  in  1  one sample presented this cycle.
- level_hit  in  levels  per-level trigger match for the current sample.
- wr_en  out  1  write current sample to buffer.
- wr_addr  out  saddr_w  buffer write address.
- ready  out  1  idle, arm accepted.
- armed  out  1  in PREFILL or WAIT_TRIG.
- triggered  out  1  final trigger level matched (sticky).
- done  out  1  capture complete (sticky).
- cur_level  out  $clog2(levels)  trigger level currently awaited.
- trigger_pos  out  saddr_w  buffer address of the trigger sample.
- start_addr  out  saddr_w  address of the oldest valid sample.

Behaviour:
- Reset values:
  - state = IDLE; ready = 1.
  - armed, triggered, done = 0.
  - wr_addr, cur_level, trigger_pos, start_addr = 0; all counters and the wrapped flag = 0.
- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE. All outputs are registered except wr_en = sample_valid & (state in PREFILL/WAIT_TRIG/POST).
- Write addressing:
  - On each wr_en, the current sample goes to wr_addr.
  - wr_addr then increments modulo N, where N is buffer_size latched at arm.
  - On wrap from N-1 to 0, set the wrapped flag.
- Priority, highest first: reset > abort > arm > sample_valid.
- IDLE:
  - arm latches buffer_size, pre_count and num_levels. pre_count is clamped to N-1.
  - arm also clears wr_addr, the counters, wrapped, cur_level, triggered and done.
  - Next state is PREFILL, or WAIT_TRIG if the clamped pre_count = 0.
- PREFILL:
  - Count written samples. level_hit is ignored.
  - When the count reaches pre_count (on the cycle that writes sample number pre_count), go to WAIT_TRIG.
- WAIT_TRIG: for each sample_valid, evaluated in the same cycle as its write:
  - If num_levels = 0, or level_hit[cur_level] = 1 and cur_level = num_levels-1:
    - trigger_pos <= wr_addr; triggered <= 1.
    - Go to POST, or straight to DONE if post_count = 0.
  - Else if level_hit[cur_level] = 1: cur_level++. Only one level advances per sample.
  - A miss does not reset cur_level.
- POST:
  - Count samples after the trigger sample.
  - post_count is sampled when POST is entered; later changes are ignored.
  - When the count reaches post_count, go to DONE.
- DONE:
  - done = 1; wr_en = 0.
  - start_addr <= wrapped ? wr_addr (next write position) : 0, registered on DONE entry.
  - arm restarts exactly as from IDLE. abort goes to IDLE and clears done/triggered.
- arm in PREFILL/WAIT_TRIG/POST is ignored.
- abort in any non-IDLE state:
  - Go to IDLE next cycle; clear armed, triggered and done.
  - Samples presented in the abort cycle are still written (wr_en is combinational) but not counted.
- abort in IDLE: no effect.
- Mid-capture reset behaves identically to power-on reset.
- Config overlap rule: if pre_count + post_count + 1 > N, the oldest pre-trigger samples are overwritten. This is legal; start_addr still marks the oldest valid sample.
- Latency: arm to armed = 1 cycle; final trigger sample to triggered = 1 cycle; last post sample to done = 1 cycle.

Test Plan:
- N=16, pre=4, post=5, num_levels=1, level_hit[0] on sample 6 (0-based) -> no trigger honoured before sample 4; trigger_pos=6; done 1 cycle after sample 11; wrapped=0, start_addr=0.
- N=8, pre=2, post=3, level 0 hit at sample 10 -> wr_addr wraps at 8; trigger_pos=2; done after sample 13; start_addr=6 (wr_addr after last write).
- num_levels=3, hits L0@5, L1@5 (same sample), L1@7, L2@9, pre=0 -> cur_level 0→1 at 5, 1→2 at 7; trigger_pos=9; level_hit[1] at sample 5 does not double-advance.
- num_levels=0, pre=3, post=0 -> trigger on sample 3, trigger_pos=3; DONE directly from WAIT_TRIG; done high the cycle after sample 3.
- abort during POST, then arm in the same cycle as a following sample -> abort cycle returns to IDLE with done=triggered=0; subsequent arm restarts with wr_addr=0; an arm issued in POST before the abort is ignored.
- reset asserted in WAIT_TRIG with sample_valid=1 -> all outputs at reset values the next cycle; wr_en=0 during reset.
